// File: rtl/feature_win_sched.sv
// rtl/feature_win_sched.sv - stride-1 KxK window-scan scheduler for the input feature memory
//
// Purpose:
//   On a start pulse, walks every KERNEL_SIZE x KERNEL_SIZE window of the
//   flattened image (row, col, ky, kx order, kx innermost). It drives the
//   feature-memory read address, captures the combinational read data into
//   an output register and streams one tap per handshake to the conv engine.
//
// Optional feature macro:
//   FEAT_ZERO_PAD_EN - "same" zero padding, P=(K-1)/2, OUT_W=IMG_WIDTH,
//                      OUT_H=IMG_HEIGHT; out-of-image taps read as 0 and
//                      drive mem_addr=0. Undefined: valid convolution only.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   start             - one-cycle frame request, ignored while busy or in the done cycle
//   mem_addr          - feature memory read address (combinational from counters)
//   mem_rdata         - signed read data, combinational from mem_addr
//   pix_data          - registered signed tap pixel
//   pix_valid/ready   - tap handshake
//   pix_last_win      - tap is the last tap (ky=kx=K-1) of its window
//   pix_last          - tap is the last tap of the frame
//   busy              - frame in progress
//   done              - one-cycle pulse after the final tap is accepted

module feature_win_sched #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_rdata,
    output logic signed [DATA_WIDTH-1:0] pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic                         pix_last_win,
    output logic                         pix_last,
    output logic                         busy,
    output logic                         done
);

`ifdef FEAT_ZERO_PAD_EN
    localparam int PAD   = (KERNEL_SIZE - 1) / 2;
    localparam int OUT_W = IMG_WIDTH;
    localparam int OUT_H = IMG_HEIGHT;
`else
    localparam int OUT_W = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int OUT_H = IMG_HEIGHT - KERNEL_SIZE + 1;
`endif

    localparam int K_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int AW1   = ADDR_W + 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [K_W-1:0]               ky_q, ky_d;
    logic [K_W-1:0]               kx_q, kx_d;
    logic signed [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                         pix_valid_q, pix_valid_d;
    logic                         last_win_q, last_win_d;
    logic                         last_q, last_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [ADDR_W-1:0]            addr_calc;
    logic                         tap_in_bounds;
    logic                         win_end;
    logic                         frame_end;

    // ------------------------------------------------------------------
    // Tap address from the live counters
    // ------------------------------------------------------------------
`ifdef FEAT_ZERO_PAD_EN
    // Two spare bits: one for the row+ky carry, one for the sign of -PAD.
    localparam int CW = ADDR_W + 2;
    logic signed [CW-1:0] y_s;
    logic signed [CW-1:0] x_s;

    always_comb begin
        y_s = $signed(CW'(row_q) + CW'(ky_q) - CW'(PAD));
        x_s = $signed(CW'(col_q) + CW'(kx_q) - CW'(PAD));
        tap_in_bounds = !y_s[CW-1] && !x_s[CW-1]
                        && (y_s < $signed(CW'(IMG_HEIGHT)))
                        && (x_s < $signed(CW'(IMG_WIDTH)));
        if (tap_in_bounds) begin
            addr_calc = ADDR_W'(AW1'(y_s) * AW1'(IMG_WIDTH) + AW1'(x_s));
        end else begin
            addr_calc = '0;
        end
    end
`else
    always_comb begin
        tap_in_bounds = 1'b1;
        addr_calc = ADDR_W'((AW1'(row_q) + AW1'(ky_q)) * AW1'(IMG_WIDTH)
                            + AW1'(col_q) + AW1'(kx_q));
    end
`endif

    always_comb begin
        win_end   = (ky_q == K_LAST) && (kx_q == K_LAST);
        frame_end = win_end && (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        last_win_d  = last_win_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done_q marks the cycle right after a frame; a start there is dropped.
                if (start && !done_q) begin
                    state_d = S_SCAN;
                    busy_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                end
            end

            S_SCAN: begin
                // Output register is free when empty or being drained this cycle.
                if (!pix_valid_q || pix_ready) begin
                    pix_data_d  = tap_in_bounds ? mem_rdata : '0;
                    pix_valid_d = 1'b1;
                    last_win_d  = win_end;
                    last_d      = frame_end;
                    if (frame_end) begin
                        // Counters stay on the final tap so mem_addr holds in DRAIN.
                        state_d = S_DRAIN;
                    end else if (kx_q != K_LAST) begin
                        kx_d = kx_q + K_W'(1);
                    end else begin
                        kx_d = '0;
                        if (ky_q != K_LAST) begin
                            ky_d = ky_q + K_W'(1);
                        end else begin
                            ky_d = '0;
                            if (col_q != COL_LAST) begin
                                col_d = col_q + COL_W'(1);
                            end else begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (pix_valid_q && pix_ready) begin
                    pix_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                pix_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            last_win_q  <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            last_win_q  <= last_win_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Address is parked at 0 between frames; it follows the counters otherwise.
    assign mem_addr     = (state_q == S_IDLE) ? '0 : addr_calc;
    assign pix_data     = pix_data_q;
    assign pix_valid    = pix_valid_q;
    assign pix_last_win = last_win_q;
    assign pix_last     = last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_feature_win_sched.sv
// tb/tb_feature_win_sched.sv - randomized self-checking bench for feature_win_sched

module tb_feature_win_sched;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int K  = 3;
    localparam int AW = $clog2(IW * IH);
`ifdef FEAT_ZERO_PAD_EN
    localparam int P  = (K - 1) / 2;
    localparam int OW = IW;
    localparam int OH = IH;
`else
    localparam int P  = 0;
    localparam int OW = IW - K + 1;
    localparam int OH = IH - K + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] mem_rdata;
    logic signed [DW-1:0] pix_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_last_win;
    logic                 pix_last;
    logic                 busy;
    logic                 done;

    logic signed [DW-1:0] mem [IW*IH];

    int n_checks = 0;
    int n_pass   = 0;

    int exp_data[$];
    bit exp_lw[$];
    bit exp_l[$];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    feature_win_sched #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .KERNEL_SIZE(K),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_last_win(pix_last_win),
        .pix_last    (pix_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Golden tap sequence: every window in raster order, taps row-major inside it.
    task automatic build_expected();
        exp_data.delete();
        exp_lw.delete();
        exp_l.delete();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        int y = r + ky - P;
                        int x = c + kx - P;
                        if (y < 0 || y >= IH || x < 0 || x >= IW) exp_data.push_back(0);
                        else exp_data.push_back(int'(mem[y * IW + x]));
                        exp_lw.push_back(ky == K - 1 && kx == K - 1);
                        exp_l.push_back(ky == K - 1 && kx == K - 1 && r == OH - 1 && c == OW - 1);
                    end
    endtask

    task automatic fill_mem(input bit rand_data);
        for (int i = 0; i < IW * IH; i++)
            mem[i] = rand_data ? DW'($urandom) : DW'(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_data"}, pix_data, 0);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_lw"}, pix_last_win, 0);
        check({tag, "_last"}, pix_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // mode 0: ready always high, 1: random 50% ready, 2: 3-cycle stall on tap index 5
    task automatic run_frame(input int mode, input int abort_at, input bit noise);
        int n = 0;
        int valid_cyc = 0;
        int bp_left = 3;
        bit seen_done = 1'b0;
        bit prev_stall = 1'b0;
        logic signed [DW-1:0] prev_data = '0;
        logic [AW-1:0] prev_addr = '0;
        logic prev_lw = 1'b0;
        logic prev_l = 1'b0;

        build_expected();
        @(negedge clk);
        check("idle_busy", busy, 0);
        start = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_no_valid", pix_valid, 0);
        @(negedge clk);
        check("first_tap_latency", pix_valid, 1);

        for (int cyc = 0; cyc < 5000 && !seen_done; cyc++) begin
            if (prev_stall) begin
                check("stall_data", pix_data, prev_data);
                check("stall_addr", mem_addr, prev_addr);
                check("stall_lw", pix_last_win, prev_lw);
                check("stall_last", pix_last, prev_l);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_tap_count", n, exp_data.size());
                check("done_busy", busy, 0);
                check("done_valid", pix_valid, 0);
                if (mode == 0) begin
                    check("valid_cycles", valid_cyc, exp_data.size());
                    check("frame_cycles", cyc, exp_data.size());
                end
                start = noise;
                @(negedge clk);
                start = 1'b0;
                check("done_one_cycle", done, 0);
                check("start_in_done_ignored", busy, 0);
            end else begin
                check("busy_scan", busy, 1);
                case (mode)
                    1: pix_ready = ($urandom_range(0, 1) == 1);
                    2: begin
                        if (pix_valid && n == 5 && bp_left > 0) begin
                            pix_ready = 1'b0;
                            bp_left--;
                        end else begin
                            pix_ready = 1'b1;
                        end
                    end
                    default: pix_ready = 1'b1;
                endcase
                start = noise && ($urandom_range(0, 3) == 0);
                if (pix_valid) valid_cyc++;
                prev_stall = pix_valid && !pix_ready;
                prev_data  = pix_data;
                prev_addr  = mem_addr;
                prev_lw    = pix_last_win;
                prev_l     = pix_last;
                if (pix_valid && pix_ready) begin
                    if (n < exp_data.size()) begin
                        check($sformatf("tap%0d_data", n), pix_data, exp_data[n]);
                        check($sformatf("tap%0d_lw", n), pix_last_win, exp_lw[n]);
                        check($sformatf("tap%0d_last", n), pix_last, exp_l[n]);
                    end else begin
                        check("extra_tap", n, exp_data.size());
                    end
                    n++;
                end
                if (abort_at > 0 && n == abort_at) begin
                    start = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk);
                    rst_n = 1'b1;
                    pix_ready = 1'b1;
                    return;
                end
                @(negedge clk);
            end
        end
        if (!seen_done) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pix_ready = 1'b0;
        fill_mem(1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_frame(0, 0, 1'b0);
        run_frame(2, 0, 1'b0);
        fill_mem(1'b1);
        run_frame(1, 0, 1'b0);
        run_frame(1, 0, 1'b1);
        run_frame(0, 0, 1'b1);
        fill_mem(1'b0);
        run_frame(0, 20, 1'b0);
        run_frame(0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/feature_win_sched.md
# feature_win_sched

Window-scan scheduler for the input feature memory. On a start pulse it walks every KERNEL_SIZE×KERNEL_SIZE convolution window of the flattened image at stride 1. It drives the feature memory's read address, registers the memory's combinational read data, and streams one pixel per tap to the convolution engine over a valid/ready handshake. Window and frame boundaries are marked on the stream.

## Interface
- DATA_WIDTH, 8: pixel width in bits, signed.
- IMG_WIDTH, 8: image columns.
- IMG_HEIGHT, 8: image rows.
- KERNEL_SIZE, 3: window edge. Must be odd, ≥1, and ≤ min(IMG_WIDTH, IMG_HEIGHT).
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT): memory address width.

Ports:
- clk input 1: single clock, rising edge.
- rst_n input 1: asynchronous, active-low reset.
- start input 1: one-cycle request to scan one frame. Ignored while busy=1.
- mem_addr output ADDR_W: read address to the feature memory.
- mem_rdata input DATA_WIDTH: signed read data. Combinational from mem_addr in the same cycle.
- pix_data output DATA_WIDTH: signed registered tap pixel.
- pix_valid output 1: pix_data is valid.
- pix_ready input 1: consumer accepts pix_data when pix_valid=1 and pix_ready=1.
- pix_last_win output 1: the current tap is the last tap (ky=kx=K-1) of its window.
- pix_last output 1: the current tap is the last tap of the last window of the frame.
- busy output 1: high from the cycle after start is accepted until done.
- done output 1: one-cycle pulse after the final tap is accepted.

## Operation
- State IDLE:
  - start=1 → SCAN. Clear the counters row, col, ky, kx to 0. Set busy=1.
- State SCAN:
  - mem_addr = (row+ky)*IMG_WIDTH + (col+kx), computed combinationally from the counters.
  - The output register loads when it is free, i.e. pix_valid=0 or pix_ready=1.
  - On load: pix_data←mem_rdata, pix_valid←1, flags computed from the pre-increment counters, then the counters advance.
  - Counter order, innermost first: kx, ky, col, row.
  - kx wraps at K-1, then ky increments.
  - ky wraps at K-1, then col increments.
  - col wraps at OUT_W-1, then row increments.
  - OUT_W = IMG_WIDTH-K+1 and OUT_H = IMG_HEIGHT-K+1 (no padding build).
  - When the tap loaded is the final tap (row=OUT_H-1, col=OUT_W-1, ky=kx=K-1) → DRAIN.
- State DRAIN:
  - No new loads. mem_addr holds its last value.
  - When the final tap is accepted: pix_valid←0, done=1 for one cycle, busy←0 → IDLE.
- Otherwise pix_valid←0 when a tap is accepted and no new load occurs.
- Back-pressure: while pix_valid=1 and pix_ready=0, pix_data, the flags, the counters and mem_addr are all frozen.
- Arithmetic: row, col, ky and kx are unsigned and sized by $clog2 of their range, minimum 1 bit. The address product is computed at ADDR_W+1 bits and truncated to ADDR_W. It never exceeds IMG_WIDTH*IMG_HEIGHT-1.
- start arriving in the same cycle as done is ignored. A new frame needs start in a later cycle.
- Reset mid-scan (rst_n=0) aborts immediately. Memory contents are not touched.

## Timing
- Reset values: mem_addr=0, pix_data=0, pix_valid=0, pix_last_win=0, pix_last=0, busy=0, done=0. State=IDLE.
- start is sampled at edge T. busy=1 and SCAN begin after T.
- The first pixel_valid appears after edge T+1, which is 2 cycles start-to-first-tap.
- With pix_ready held high: one tap per cycle, and a frame takes OUT_W*OUT_H*K*K cycles of pix_valid.
- done pulses in the cycle after the final tap handshake. busy falls together with that done pulse.

## Configuration
- FEAT_ZERO_PAD_EN not defined:
  - Valid convolution only.
  - OUT_W = IMG_WIDTH-K+1 and OUT_H = IMG_HEIGHT-K+1.
- FEAT_ZERO_PAD_EN defined:
  - "Same" padding with P=(K-1)/2, so OUT_W = IMG_WIDTH and OUT_H = IMG_HEIGHT.
  - Tap coordinates are y=row+ky-P and x=col+kx-P, evaluated as signed values.
  - A tap outside the image loads pix_data=0, and mem_addr is driven to 0.
  - An in-bounds tap uses address y*IMG_WIDTH+x.
  - Handshake, flags and counter order are unchanged.

## Test plan
- Unpadded 4×4 image, mem[i]=i, K=3, pix_ready=1 → 36 taps. Each window's pix_last_win falls on taps 9, 18, 27 and 36; pix_last only on tap 36.
  - First window taps 0,1,2,4,5,6,8,9,10.
  - Last window taps 5,6,7,9,10,11,13,14,15.
  - done pulses once, 1 cycle after tap 36.
- Back-pressure: same setup, pix_ready low for 3 cycles while tap 5 (value 5) is presented → pix_data stays 5 and mem_addr stays constant. Taps resume as 6, 8, ... with no loss or duplication.
- Random pix_ready, 50% duty, on an 8×8 image with K=3 → exactly 324 accepted taps in row-major window order, matching a golden model. A single done pulse.
- start pulsed during SCAN and in the done cycle → ignored. The tap count is unchanged.
- rst_n asserted at tap 20 → all outputs are 0 in the same cycle. A subsequent start rescans from tap value 0.
- With FEAT_ZERO_PAD_EN, 4×4 image, mem[i]=i+1 → 144 taps.
  - First window taps are 0,0,0,0,1,2,0,5,6.
  - Last window taps are 11,12,0,15,16,0,0,0,0.
